// File: rtl/clint_timer.sv
// Machine timer / software-interrupt controller: mtime, mtimecmp and msip behind a
// single-outstanding valid/ready register port, driving MTIP and MSIP.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              count_stop,
    output logic [63:0]       mtime_o,
    output logic              mtip,
    output logic              msip
);

    localparam int unsigned PRESC_W = 16;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    localparam logic [ADDR_W-1:0] A_MSIP   = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'(16'hBFFC);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state, state_next;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [PRESC_W-1:0] presc;
    logic               msip_q;

    logic        accept;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic        addr_err;
    logic        wr;
    logic [31:0] rd_c;

    assign accept = req_valid && req_ready;

    // Address decode and read mux
    always_comb begin
        sel_msip   = (req_addr == A_MSIP);
        sel_cmp_lo = (req_addr == A_CMP_LO);
        sel_cmp_hi = (req_addr == A_CMP_HI);
        sel_mt_lo  = (req_addr == A_MT_LO);
        sel_mt_hi  = (req_addr == A_MT_HI);
        addr_err   = (req_addr[1:0] != 2'b00) ||
                     !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_mt_lo || sel_mt_hi);
        wr         = accept && req_we && !addr_err;
        rd_c       = 32'h0;
        if (sel_msip)   rd_c = {31'h0, msip_q};
        if (sel_cmp_lo) rd_c = mtimecmp[31:0];
        if (sel_cmp_hi) rd_c = mtimecmp[63:32];
        if (sel_mt_lo)  rd_c = mtime[31:0];
        if (sel_mt_hi)  rd_c = mtime[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Response payload is captured on accept and held until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= (req_we || addr_err) ? 32'h0 : rd_c;
            rsp_err   <= addr_err;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end
    end

    // A software write to either mtime half overrides a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= 64'h0;
            presc <= '0;
        end else if (wr && (sel_mt_lo || sel_mt_hi)) begin
            presc <= '0;
            if (sel_mt_lo) mtime[31:0]  <= req_wdata;
            else           mtime[63:32] <= req_wdata;
        end else if (!count_stop) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q   <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            if (wr && sel_cmp_lo) mtimecmp[31:0]  <= req_wdata;
            if (wr && sel_cmp_hi) mtimecmp[63:32] <= req_wdata;
            if (wr && sel_msip)   msip_q          <= req_wdata[0];
            mtip <= (mtime >= mtimecmp);
        end
    end

    assign mtime_o = mtime;
    assign msip    = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: bus protocol, register map, tick/compare timing,
// prescaled counting with debug stop, and asynchronous reset.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst_n, rst4_n;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        count_stop;
    logic [63:0] mtime_o;
    logic        mtip, msip;

    logic        stop4, req_ready4, rsp_valid4, rsp_err4, mtip4, msip4;
    logic [31:0] rsp_rdata4;
    logic [63:0] mtime4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .count_stop(count_stop), .mtime_o(mtime_o), .mtip(mtip), .msip(msip)
    );

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst4_n),
        .req_valid(1'b0), .req_ready(req_ready4), .req_we(1'b0),
        .req_addr(16'h0), .req_wdata(32'h0),
        .rsp_valid(rsp_valid4), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
        .count_stop(stop4), .mtime_o(mtime4), .mtip(mtip4), .msip(msip4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the accept edge
    task automatic bus_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 20) begin
            cyc(1);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
        cyc(1);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic bus_rsp(output logic [31:0] rdata, output logic err);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        rdata     = rsp_rdata;
        err       = rsp_err;
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
        check("req_ready_after_rsp", 64'(req_ready), 64'd1);
    endtask

    task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        bus_req(we, addr, wdata);
        bus_rsp(rdata, err);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;

        rst_n = 1'b0; rst4_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0; count_stop = 1'b0; stop4 = 1'b0;
        cyc(3);

        check("rst_mtip", 64'(mtip), 64'd0);
        check("rst_msip", 64'(msip), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mtime", mtime_o, 64'd0);

        rst_n = 1'b1;
        cyc(5);
        check("mtime_after_5", mtime_o, 64'd5);

        bus_xfer(1'b0, 16'h4004, 32'h0, rd, er);
        check("cmp_hi_rst_rd", 64'(rd), 64'hFFFF_FFFF);
        check("cmp_hi_rst_err", 64'(er), 64'd0);

        // Compare match timing
        bus_xfer(1'b1, 16'h4004, 32'h0, rd, er);
        bus_xfer(1'b1, 16'h4000, 32'd20, rd, er);
        check("cmp_wr_err", 64'(er), 64'd0);
        n = 0;
        while (mtime_o != 64'd20 && n < 100) begin
            cyc(1);
            n++;
        end
        check("mtime_reach_20", mtime_o, 64'd20);
        check("mtip_before_rise", 64'(mtip), 64'd0);
        cyc(1);
        check("mtip_rise", 64'(mtip), 64'd1);
        bus_req(1'b1, 16'h4000, 32'd1000);
        check("mtip_at_cmp_accept", 64'(mtip), 64'd1);
        bus_rsp(rd, er);
        check("mtip_fall", 64'(mtip), 64'd0);

        // 64-bit wrap
        count_stop = 1'b1;
        bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, er);
        bus_xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd, er);
        check("mtime_all_ones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        count_stop = 1'b0;
        cyc(1);
        check("mtime_wrap", mtime_o, 64'd0);

        // Write coincident with a tick: write wins, no carry into the other half
        bus_req(1'b1, 16'hBFF8, 32'h1234_5678);
        check("mtime_wr_wins", mtime_o, 64'h0000_0000_1234_5678);
        bus_rsp(rd, er);
        check("mtime_resume", mtime_o, 64'h0000_0000_1234_5679);
        bus_xfer(1'b0, 16'hBFF8, 32'h0, rd, er);
        check("mtime_lo_rd", 64'(rd), 64'h1234_5679);
        bus_req(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
        check("mtime_lo_ff", mtime_o, 64'h0000_0000_FFFF_FFFF);
        bus_rsp(rd, er);
        check("mtime_carry", mtime_o, 64'h0000_0001_0000_0000);
        bus_xfer(1'b0, 16'hBFFC, 32'h0, rd, er);
        check("mtime_hi_rd", 64'(rd), 64'd1);

        // msip and error responses
        bus_xfer(1'b1, 16'h0000, 32'h3, rd, er);
        check("msip_set", 64'(msip), 64'd1);
        bus_xfer(1'b0, 16'h0000, 32'h0, rd, er);
        check("msip_rd", 64'(rd), 64'd1);
        check("msip_rd_err", 64'(er), 64'd0);
        bus_xfer(1'b0, 16'h0002, 32'h0, rd, er);
        check("misalign_err", 64'(er), 64'd1);
        check("misalign_rd", 64'(rd), 64'd0);
        bus_xfer(1'b1, 16'h1234, 32'h5, rd, er);
        check("unmapped_err", 64'(er), 64'd1);
        check("unmapped_rd", 64'(rd), 64'd0);
        bus_xfer(1'b1, 16'h0002, 32'h0, rd, er);
        check("misalign_wr_err", 64'(er), 64'd1);
        check("msip_kept", 64'(msip), 64'd1);
        bus_xfer(1'b0, 16'h4000, 32'h0, rd, er);
        check("cmp_lo_kept", 64'(rd), 64'd1000);

        // Backpressure on the response
        bus_req(1'b0, 16'h0000, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_rdata", 64'(rsp_rdata), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            cyc(1);
        end
        bus_rsp(rd, er);
        check("hold_final_rd", 64'(rd), 64'd1);

        // Asynchronous reset with a response outstanding
        count_stop = 1'b1;
        bus_xfer(1'b1, 16'hBFFC, 32'h0, rd, er);
        bus_xfer(1'b1, 16'hBFF8, 32'd500, rd, er);
        bus_xfer(1'b1, 16'h4000, 32'd100, rd, er);
        check("pre_rst_mtime", mtime_o, 64'd500);
        check("pre_rst_mtip", 64'(mtip), 64'd1);
        bus_req(1'b0, 16'h0000, 32'h0);
        check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_mtime", mtime_o, 64'd0);
        check("arst_msip", 64'(msip), 64'd0);
        check("arst_mtip", 64'(mtip), 64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        count_stop = 1'b0;
        cyc(1);
        rst_n = 1'b1;

        // TICK_DIV = 4 with a debug stop mid-count
        check("d4_rst_mtime", mtime4, 64'd0);
        check("d4_rst_ready", 64'(req_ready4), 64'd1);
        check("d4_rst_outs", {58'h0, rsp_valid4, rsp_err4, mtip4, msip4, 1'b0, |rsp_rdata4}, 64'd0);
        rst4_n = 1'b1;
        cyc(6);
        check("d4_after_6", mtime4, 64'd1);
        stop4 = 1'b1;
        cyc(5);
        check("d4_stop_mid", mtime4, 64'd1);
        cyc(5);
        check("d4_stop_end", mtime4, 64'd1);
        stop4 = 1'b0;
        cyc(1);
        check("d4_resume_1", mtime4, 64'd1);
        cyc(1);
        check("d4_resume_2", mtime4, 64'd2);
        cyc(3);
        check("d4_resume_5", mtime4, 64'd2);
        cyc(1);
        check("d4_resume_6", mtime4, 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Machine-level timer and software-interrupt controller for the single hart.
- Maintains the 64-bit mtime counter, the mtimecmp compare register and the msip bit.
- Drives the MTIP and MSIP pending inputs of the CSR file's mip register (bits 7 and 3).
- Is configured by software over a simple single-outstanding valid/ready memory-mapped port decoded from the data-memory path.

Parameters:
- TICK_DIV, 1: clk cycles per mtime increment; legal range 1..65535.
- ADDR_W, 16: width of the register-offset address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte offset
- req_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  unmapped or misaligned access
- count_stop  in  1  debug halt; freezes mtime while high
- mtime_o  out  64  current mtime, for the time/timeh CSRs
- mtip  out  1  timer interrupt pending
- msip  out  1  software interrupt pending

Behaviour:
- Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, mtip = 0, prescaler = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. The reset value of req_ready is 1.
- Register map (offsets):
  - 0x0000 msip; bit 0 is R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- Bus handshake:
  - States are IDLE and RESP.
  - req_ready = 1 in IDLE and 0 in RESP. At most one request is outstanding.
  - On acceptance in IDLE: go to RESP the next cycle with rsp_valid = 1. Read data and rsp_err are registered. Read latency is 1 cycle.
  - In RESP, rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready. Then return to IDLE, so req_ready = 1 on the following cycle.
  - There is no same-cycle response/accept overlap, so the maximum throughput is 1 request per 2 cycles.
- Errors: a request with req_addr[1:0] != 0, or with an unmapped offset, completes with rsp_err = 1 and rsp_rdata = 0. No register changes.
- Writes are full 32-bit. They take effect at the end of the accept cycle, so a read accepted on the next opportunity returns the new value.
- Counter:
  - The prescaler counts 0..TICK_DIV-1 while count_stop = 0.
  - In the cycle the prescaler equals TICK_DIV-1: the prescaler goes to 0 and mtime increments by 1. The increment is a full 64-bit carry and wraps from 2^64-1 to 0.
  - TICK_DIV = 1 means mtime increments every cycle.
  - count_stop = 1 holds both the prescaler and mtime.
- Simultaneous events:
  - A write to either mtime half in the same cycle as a tick: the write wins, the tick is lost, and the prescaler resets to 0.
  - The other mtime half keeps its pre-write value. There is no carry into the unwritten half.
- Read of an mtime half returns the value registered at the end of the accept cycle, i.e. the pre-increment value. There is no hi/lo snapshot; software uses the hi-lo-hi loop.
- mtime_o is the mtime register itself, with no extra delay.
- mtip is registered: mtip <= (mtime >= mtimecmp), an unsigned 64-bit compare of current register values. It therefore lags a change of mtime or mtimecmp by 1 cycle. It stays asserted while the condition holds and clears 1 cycle after mtimecmp is written above mtime.
- msip is the msip register bit 0, driven directly.
- Reset mid-transaction: an outstanding response is dropped (rsp_valid -> 0 immediately) and all registers return to their reset values.

Test Plan:
- Reset, TICK_DIV = 1, count_stop = 0. Required: mtip = 0, msip = 0, req_ready = 1, and mtime_o = N exactly N cycles after reset release. Read 0x4004 -> rsp_rdata = 32'hFFFF_FFFF, rsp_err = 0.
- Write 0x4004 = 0, then write 0x4000 = 20. Required: mtip rises exactly 1 cycle after mtime_o reaches 20. Write 0x4000 = 1000 -> mtip falls 1 cycle after the accept.
- Write 0xBFF8 = 32'hFFFF_FFFF and 0xBFFC = 32'hFFFF_FFFF. Required: on the next tick mtime_o = 0. Also force a tick coincident with the 0xBFF8 write and confirm mtime_o[31:0] equals the written value and is not incremented.
- TICK_DIV = 4, count_stop pulsed high for 10 cycles mid-count. Required: mtime advances once per 4 unstopped cycles, and mtime and prescaler are frozen during the stop.
- Write 0x0000 = 32'h3 -> msip = 1, and a read returns 32'h1. Access 0x0002 and 0x1234 -> rsp_err = 1, rsp_rdata = 0, no state change. Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0.
- Assert rst_n = 0 while rsp_valid = 1 with mtime = 500 and msip = 1. Required: rsp_valid = 0, mtime_o = 0, msip = 0 and mtip = 0 immediately, asynchronously.
